eep_spi_resp: RTL and testbench
===============================

Name: eep_spi_resp

Overview:
SPI responder (slave) model of the calibration EEPROM that sits on ss = 3'b100 of the DSO SPI bus. It decodes the 16-bit frames the command processor sends through the SPI master: write {2'b01, addr[5:0], data[7:0]} and read {2'b00, addr[5:0], 8'hxx}. Read data is returned in the low byte of the next frame. It gives the team a synthesizable EEPROM for full-chip simulation and FPGA bring-up, and holds 64 x 8 offset/gain calibration bytes.

Parameters:
WR_CYCLES, 64, clk cycles the write-busy window lasts after a committed write (1..255)
INIT_VAL, 8'h00, value loaded into every memory byte at reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
SS_n  input  1  slave select, active-low; SPI master ss decode of 3'b100
SCLK  input  1  SPI serial clock, mode 0, idle low
MOSI  input  1  serial data from master, MSB first
MISO  output  1  serial data to master
wr_busy  output  1  high while the write-busy window runs
frame_err  output  1  one-clk pulse when a frame ends with bit count != 16
wr_done  output  1  one-clk pulse when a write commits to memory

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, bit_cnt=0, rx_shft=0, tx_shft=16'h0000, MISO=0, wr_busy=0, busy_cnt=0, frame_err=0, wr_done=0, all 64 bytes=INIT_VAL. Reset mid-frame abandons the frame. After reset, the remaining bits of that frame are ignored until SS_n is seen high.
- Inputs SS_n, SCLK, MOSI each pass through 2 flops; SS_n resets to 1 and SCLK to 0. One more stage gives edge detect: sclk_rise, sclk_fall, ss_fall, ss_rise. The spec requires SCLK high and low phases >= 4 clk.
- MOSI is sampled on sclk_rise, using the synchronized MOSI aligned to the same stage as SCLK. It shifts into rx_shft LSB and bit_cnt increments. bit_cnt is 5 bits and saturates at 31.
- On sclk_fall, tx_shft shifts left and 0 fills from the LSB. MISO = tx_shft[15] while SS_n(sync) low and 0 when high. MISO is registered: it changes 1 clk after sclk_fall is detected. The first bit is valid from ss_fall + 1 clk.
- FSM:
  - IDLE: on ss_fall, clear bit_cnt and go to SHIFT.
  - SHIFT: on ss_rise, go to DECODE. sclk edges act only in SHIFT.
  - DECODE (1 clk): act on rx_shft, then go to IDLE.
- DECODE rules; bits [15:14] are the op code:
  - bit_cnt != 16: pulse frame_err, memory unchanged, tx_shft=16'h0000.
  - 2'b01 write, not busy: mem[rx_shft[13:8]] <= rx_shft[7:0]; pulse wr_done; wr_busy=1; busy_cnt=WR_CYCLES; tx_shft=16'h0000.
  - 2'b01 write, busy: the write is dropped, with no wr_done pulse; tx_shft=16'h0000.
  - 2'b00 read, not busy: tx_shft={8'h00, mem[rx_shft[13:8]]}. The master's next frame (any content) receives this data in its low byte.
  - 2'b00 read, busy: tx_shft=16'h00FF.
  - 2'b10 / 2'b11: no operation; tx_shft=16'h0000.
- Busy counter: decrements each clk while nonzero. wr_busy drops in the clk after busy_cnt reaches 0. A new write in the same DECODE cycle that busy_cnt reaches 0 still counts as busy.
- A read after a write to the same address, once busy has ended, returns the new data.
- If an ss_fall arrives while in DECODE, it is not lost. The spec requires SS_n high time >= 4 clk, so the FSM reaches IDLE first.
- Memory is a 64 x 8 register array. It has a single write port and an asynchronous read used only in DECODE.

Optional Feature:
Macro EEP_WRT_PROT_EN.
- Defined: adds input port WP (1 bit, active-high, synchronized by 2 flops). When WP(sync) is 1 in DECODE, write frames are treated like the busy case: no write, no wr_done, no busy window. Reads are unaffected.
- Not defined: the port is absent and every write that is not busy commits.

Test Plan:
- Reset with INIT_VAL=8'h00, then send read frame 16'h0500 followed by frame 16'h0000 -> the second frame's MISO low byte = 8'h00, and frame_err stays 0.
- Write 16'h45A7 (addr 5, data A7) -> wr_done pulses once and wr_busy is high for 64 clk. Then, after busy ends, read 16'h0500 plus one dummy frame -> dummy-frame MISO = 16'h00A7.
- Write 16'h4311, then immediately read 16'h0300 while wr_busy -> next frame returns 16'h00FF. After busy ends, the read returns 16'h0011. A second write 16'h4322 sent during busy is dropped, and the re-read gives 8'h11.
- Send a 12-bit frame (SS_n rises after 12 SCLKs) -> frame_err pulses 1 clk, memory unchanged, next frame MISO = 16'h0000. Send a 17-bit frame -> frame_err again.
- Assert rst during bit 8 of a write frame 16'h7F3C -> all outputs return to their reset values, and mem[0x3F] stays INIT_VAL after the frame completes. The next full read of 0x3F returns INIT_VAL.
- With EEP_WRT_PROT_EN defined and WP=1, write 16'h4A55 -> no wr_done and no busy, and a read of addr 0x0A returns the old value. With WP=0, the same write commits 8'h55.

Source files
------------

// File: rtl/eep_spi_resp.sv
// SPI mode-0 responder modelling the 64 x 8 calibration EEPROM on the DSO SPI bus.
// Optional write-protect input WP is enabled by defining EEP_WRT_PROT_EN.
module eep_spi_resp #(
  parameter int unsigned WR_CYCLES = 64,
  parameter logic [7:0]  INIT_VAL  = 8'h00
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
`ifdef EEP_WRT_PROT_EN
  input  logic WP,
`endif
  output logic MISO,
  output logic wr_busy,
  output logic frame_err,
  output logic wr_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  state_t      state_q;
  logic [2:0]  ss_q;
  logic [2:0]  sclk_q;
  logic [1:0]  mosi_q;
  logic [1:0]  vld_q;
  logic        armed_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] rx_q;
  logic [15:0] tx_q;
  logic [15:0] tx_d;
  logic        miso_q;
  logic        busy_q;
  logic [7:0]  busy_cnt_q;
  logic        ferr_q;
  logic        wdone_q;
  logic [7:0]  mem_q [64];

  logic        sclk_rise;
  logic        sclk_fall;
  logic        ss_fall;
  logic        ss_rise;
  logic        wp_blk;
  logic [1:0]  op;
  logic [5:0]  addr;
  logic        frame_ok;
  logic        do_write;

  // Handshake: a frame is SS_n low, 16 mode-0 SCLK pulses (MOSI sampled on rise,
  // MISO updated after fall), then SS_n high; the frame is decoded one clk later.

`ifdef EEP_WRT_PROT_EN
  logic [1:0] wp_q;
  always_ff @(posedge clk) begin
    if (rst) wp_q <= 2'b00;
    else     wp_q <= {wp_q[0], WP};
  end
  assign wp_blk = wp_q[1];
`else
  assign wp_blk = 1'b0;
`endif

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  // armed_q masks the false fall produced when SS_n is already low coming out of reset.
  assign ss_fall   = armed_q & ss_q[2] & ~ss_q[1];
  assign ss_rise   = ss_q[1] & ~ss_q[2];

  assign op       = rx_q[15:14];
  assign addr     = rx_q[13:8];
  assign frame_ok = (bit_cnt_q == 5'd16);
  assign do_write = (state_q == DECODE) && frame_ok && (op == 2'b01) && !busy_q && !wp_blk;

  always_comb begin
    tx_d = tx_q;
    if (state_q == DECODE) begin
      tx_d = 16'h0000;
      if (frame_ok && (op == 2'b00)) begin
        tx_d = busy_q ? 16'h00FF : {8'h00, mem_q[addr]};
      end
    end else if ((state_q == SHIFT) && sclk_fall) begin
      tx_d = {tx_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ss_q       <= 3'b111;
      sclk_q     <= 3'b000;
      mosi_q     <= 2'b00;
      vld_q      <= 2'b00;
      armed_q    <= 1'b0;
      bit_cnt_q  <= 5'd0;
      rx_q       <= 16'h0000;
      tx_q       <= 16'h0000;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      busy_cnt_q <= 8'd0;
      ferr_q     <= 1'b0;
      wdone_q    <= 1'b0;
      for (int i = 0; i < 64; i++) mem_q[i] <= INIT_VAL;
    end else begin
      ss_q    <= {ss_q[1:0], SS_n};
      sclk_q  <= {sclk_q[1:0], SCLK};
      mosi_q  <= {mosi_q[0], MOSI};
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ss_q[1]);
      tx_q    <= tx_d;
      miso_q  <= ~ss_q[1] & tx_d[15];
      ferr_q  <= 1'b0;
      wdone_q <= 1'b0;

      if (do_write) begin
        busy_cnt_q <= 8'(WR_CYCLES);
        busy_q     <= 1'b1;
      end else begin
        if (busy_cnt_q != 8'd0) busy_cnt_q <= busy_cnt_q - 8'd1;
        busy_q <= (busy_cnt_q != 8'd0);
      end

      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            bit_cnt_q <= 5'd0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state_q <= DECODE;
          end else if (sclk_rise) begin
            rx_q <= {rx_q[14:0], mosi_q[1]};
            if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end
        DECODE: begin
          ferr_q <= !frame_ok;
          if (do_write) begin
            mem_q[addr] <= rx_q[7:0];
            wdone_q     <= 1'b1;
          end
          if (ss_fall) begin
            bit_cnt_q <= 5'd0;
            state_q   <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO      = miso_q;
  assign wr_busy   = busy_q;
  assign frame_err = ferr_q;
  assign wr_done   = wdone_q;

endmodule

// File: tb/tb_eep_spi_resp.sv
// Bench for eep_spi_resp: drives SPI frames, compares returned data and pulses
// against a transaction-level EEPROM model (array memory plus busy window in clk time).
module tb_eep_spi_resp;

  localparam int unsigned WR   = 255;
  localparam logic [7:0]  INIT = 8'h00;

  logic clk = 1'b0;
  logic rst, ss_n, sclk, mosi;
  logic miso, wr_busy, frame_err, wr_done;
`ifdef EEP_WRT_PROT_EN
  logic wp = 1'b0;
`endif

  eep_spi_resp #(.WR_CYCLES(WR), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi),
`ifdef EEP_WRT_PROT_EN
    .WP(wp),
`endif
    .MISO(miso), .wr_busy(wr_busy), .frame_err(frame_err), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_ferr = 0;
  int n_wdone = 0;
  int busy_len = 0;
  int passed = 0;
  int total = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (wr_done) n_wdone++;
    if (wr_busy) busy_len++;
  end

  // Reference model state
  logic [7:0]  m_mem [64];
  logic [15:0] m_resp;
  bit          m_have;
  int          m_commit;
  bit          m_wp = 1'b0;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = INIT;
    m_resp = 16'h0000;
    m_have = 1'b0;
    m_commit = 0;
  endtask

  // Frame decode happens a fixed delay after SS_n rises, so SS_n rise times
  // stand in for decode times when measuring the busy window.
  task automatic model_frame(input logic [15:0] w, input int nbits, input int rise,
                             output int e_err, output int e_done);
    bit busy;
    busy = m_have && ((rise - m_commit) <= int'(WR) + 1);
    e_err = 0;
    e_done = 0;
    m_resp = 16'h0000;
    if (nbits != 16) begin
      e_err = 1;
    end else if (w[15:14] == 2'b01) begin
      if (!busy && !m_wp) begin
        m_mem[w[13:8]] = w[7:0];
        e_done = 1;
        m_have = 1'b1;
        m_commit = rise;
      end
    end else if (w[15:14] == 2'b00) begin
      m_resp = busy ? 16'h00FF : {8'h00, m_mem[w[13:8]]};
    end
  endtask

  task automatic send_bit(input logic b, output logic sampled);
    mosi = b;
    wait_clk(2);
    sampled = miso;
    sclk = 1'b1;
    wait_clk(6);
    sclk = 1'b0;
    wait_clk(4);
  endtask

  task automatic run_frame(input logic [15:0] w, input int nbits,
                           output logic [15:0] rx, output int rise);
    logic s;
    rx = 16'h0000;
    ss_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      send_bit((i < 16) ? w[15-i] : 1'b0, s);
      if (i < 16) rx = {rx[14:0], s};
    end
    wait_clk(6);
    ss_n = 1'b1;
    rise = cyc;
    wait_clk(8);
  endtask

  task automatic check_frame(input string name, input logic [15:0] w, input int nbits);
    logic [15:0] rx, exp_rx;
    int rise, f0, d0, e_err, e_done;
    exp_rx = m_resp;
    f0 = n_ferr;
    d0 = n_wdone;
    run_frame(w, nbits, rx, rise);
    model_frame(w, nbits, rise, e_err, e_done);
    if (nbits == 16) begin
      total++;
      if (rx !== exp_rx) $display("FAIL %s miso_word w=%h: got %h expected %h", name, w, rx, exp_rx);
      else passed++;
    end
    total++;
    if (n_ferr - f0 != e_err) $display("FAIL %s frame_err_pulses w=%h: got %0d expected %0d", name, w, n_ferr - f0, e_err);
    else passed++;
    total++;
    if (n_wdone - d0 != e_done) $display("FAIL %s wr_done_pulses w=%h: got %0d expected %0d", name, w, n_wdone - d0, e_done);
    else passed++;
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({miso, wr_busy, frame_err, wr_done} !== 4'b0000)
      $display("FAIL %s outputs {miso,busy,ferr,done}: got %b expected 0000", name,
               {miso, wr_busy, frame_err, wr_done});
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(4);
    check_idle_outputs("reset_held");
    rst = 1'b0;
    model_reset();
    wait_clk(6);
    check_idle_outputs("after_reset");
  endtask

  task automatic test_read_init();
    check_frame("read_init", 16'h0500, 16);
    check_frame("read_init_dummy", 16'h0000, 16);
  endtask

  task automatic test_write_busy();
    busy_len = 0;
    check_frame("write_a7", 16'h45A7, 16);
    for (int k = 0; k < 600 && wr_busy; k++) wait_clk(1);
    total++;
    if (wr_busy !== 1'b0) $display("FAIL busy_end: got wr_busy=%b expected 0 within budget", wr_busy);
    else passed++;
    // load cycle plus WR decrements: window is WR or WR+1 clk depending on edge counting
    total++;
    if (busy_len < int'(WR) || busy_len > int'(WR) + 1)
      $display("FAIL busy_len: got %0d expected %0d..%0d", busy_len, WR, WR + 1);
    else passed++;
    check_frame("read_a7", 16'h0500, 16);
    check_frame("read_a7_dummy", 16'h0000, 16);
  endtask

  task automatic test_busy_read();
    check_frame("write_11", 16'h4311, 16);
    check_frame("read_busy", 16'h0300, 16);
    check_frame("read_busy_dummy", 16'h0000, 16);
    wait_clk(300);
    check_frame("read_11", 16'h0300, 16);
    check_frame("read_11_dummy", 16'h0000, 16);
  endtask

  task automatic test_busy_drop();
    wait_clk(300);
    check_frame("write_44", 16'h4344, 16);
    check_frame("write_22_dropped", 16'h4322, 16);
    check_frame("reread", 16'h0300, 16);
    check_frame("reread_dummy", 16'h0000, 16);
  endtask

  task automatic test_frame_err();
    wait_clk(300);
    check_frame("short12", 16'h4A5A, 12);
    check_frame("after_short", 16'h0500, 16);
    check_frame("long17", 16'h4A5A, 17);
    check_frame("after_long", 16'h0A00, 16);
    check_frame("after_long_dummy", 16'h0000, 16);
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    logic s;
    int f0, d0;
    w = 16'h7F3C;
    wait_clk(300);
    check_frame("write_3f", 16'h7FC3, 16);
    ss_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 8; i++) send_bit(w[15-i], s);
    rst = 1'b1;
    wait_clk(2);
    check_idle_outputs("mid_reset_held");
    rst = 1'b0;
    model_reset();
    f0 = n_ferr;
    d0 = n_wdone;
    wait_clk(1);
    check_idle_outputs("mid_reset_released");
    for (int i = 8; i < 16; i++) send_bit(w[15-i], s);
    wait_clk(6);
    ss_n = 1'b1;
    wait_clk(10);
    total++;
    if ((n_ferr != f0) || (n_wdone != d0))
      $display("FAIL abandoned_frame pulses ferr/done: got %0d/%0d expected 0/0", n_ferr - f0, n_wdone - d0);
    else passed++;
    check_frame("read_3f", 16'h3F00, 16);
    check_frame("read_3f_dummy", 16'h0000, 16);
  endtask

  task automatic test_random();
    logic [15:0] w;
    wait_clk(300);
    for (int n = 0; n < 24; n++) begin
      w = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) w[15:14] = 2'b01;
      check_frame("random", w, 16);
      if ($urandom_range(0, 1) == 1) wait_clk(300);
    end
    check_frame("random_tail", 16'h0000, 16);
  endtask

`ifdef EEP_WRT_PROT_EN
  task automatic test_write_protect();
    wait_clk(300);
    wp = 1'b1; m_wp = 1'b1;
    wait_clk(4);
    check_frame("wp_write", 16'h4A55, 16);
    check_frame("wp_read", 16'h0A00, 16);
    check_frame("wp_read_dummy", 16'h0000, 16);
    wp = 1'b0; m_wp = 1'b0;
    wait_clk(4);
    check_frame("nowp_write", 16'h4A55, 16);
    wait_clk(300);
    check_frame("nowp_read", 16'h0A00, 16);
    check_frame("nowp_read_dummy", 16'h0000, 16);
  endtask
`endif

  initial begin
    test_reset();
    test_read_init();
    test_write_busy();
    test_busy_read();
    test_busy_drop();
    test_frame_err();
    test_reset_mid();
    test_random();
`ifdef EEP_WRT_PROT_EN
    test_write_protect();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
